skinny_serial_io: RTL and testbench

Parametrised serial I/O front end for the SKINNY encryption core, covering all six SKINNY-n/t variants. It loads plaintext and tweakey one cell per beat over a valid/ready handshake and presents them in parallel to the core with a one-cycle start pulse. It captures the ciphertext on the core's completion strobe and streams it back one cell per beat under backpressure. It sits between the chip-level byte interface and `skinny_top`'s round datapath.

---
 rtl/skinny_pkg.sv | 32 +++
 rtl/skinny_cell_shifter.sv | 33 +++
 rtl/skinny_serial_io.sv | 168 ++++++++++++++++
 tb/tb_skinny_serial_io.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/skinny_pkg.sv
// Shared definitions for the SKINNY serial I/O front end: cell geometry,
// beat count, FSM state encoding and parameter legality helpers.
package skinny_pkg;

    localparam int BEATS = 16;
    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        UNLOAD
    } state_t;

    function automatic int cell_bits(input int block_bits);
        return block_bits / BEATS;
    endfunction

    function automatic int tk_bits(input int block_bits, input int tk_z);
        return block_bits * tk_z;
    endfunction

    function automatic bit block_bits_legal(input int block_bits);
        return (block_bits == 64) || (block_bits == 128);
    endfunction

    function automatic bit tk_z_legal(input int tk_z);
        return (tk_z >= 1) && (tk_z <= 3);
    endfunction

endpackage

// File: rtl/skinny_cell_shifter.sv
// Register with parallel load and a left shift by STEP bits; the top STEP
// bits are presented as the current cell.
module skinny_cell_shifter #(
    parameter int WIDTH = 128,
    parameter int STEP  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic [STEP-1:0]  shift_in,
    output logic [WIDTH-1:0] data,
    output logic [STEP-1:0]  msb
);

    logic [WIDTH-1:0] data_reg;

    // Load wins over shift so a capture is never corrupted by a stray shift.
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= load_data;
        end else if (shift) begin
            data_reg <= {data_reg[WIDTH-STEP-1:0], shift_in};
        end
    end

    assign data = data_reg;
    assign msb  = data_reg[WIDTH-1 -: STEP];

endmodule

// File: rtl/skinny_serial_io.sv
// Serial load / parallel start / serial unload wrapper around the SKINNY
// round core, for every SKINNY-n/t variant.
module skinny_serial_io
    import skinny_pkg::*;
#(
    parameter int BLOCK_BITS = 128,
    parameter int TK_Z       = 3,
    localparam int CELL      = cell_bits(BLOCK_BITS),
    localparam int TK_BITS   = tk_bits(BLOCK_BITS, TK_Z)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CELL-1:0]      in_pt,
    input  logic [TK_Z*CELL-1:0] in_tk,
    output logic                 core_start,
    output logic [BLOCK_BITS-1:0] core_pt,
    output logic [TK_BITS-1:0]   core_tk,
    input  logic                 core_done,
    input  logic [BLOCK_BITS-1:0] core_ct,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CELL-1:0]      out_ct,
    output logic                 out_last,
    output logic                 done,
    output logic                 busy
);

    if (!block_bits_legal(BLOCK_BITS)) begin : g_bad_block_bits
        $error("skinny_serial_io: BLOCK_BITS must be 64 or 128");
    end
    if (!tk_z_legal(TK_Z)) begin : g_bad_tk_z
        $error("skinny_serial_io: TK_Z must be 1, 2 or 3");
    end

    state_t     state_reg, state_next;
    logic [3:0] count_reg, count_next;
    logic       in_ready_reg, in_ready_next;
    logic       core_start_reg, core_start_next;
    logic       out_valid_reg, out_valid_next;
    logic       out_last_reg, out_last_next;
    logic       done_reg, done_next;
    logic       busy_reg, busy_next;

    logic in_accept;
    logic out_xfer;
    logic ct_capture;

    assign in_accept  = in_valid && in_ready_reg;
    assign out_xfer   = out_valid_reg && out_ready;
    assign ct_capture = (state_reg == WAIT) && core_done;

    // State register; outputs are registered from their next-state decode.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            in_ready_reg   <= 1'b0;
            core_start_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            in_ready_reg   <= in_ready_next;
            core_start_reg <= core_start_next;
            out_valid_reg  <= out_valid_next;
            out_last_reg   <= out_last_next;
            done_reg       <= done_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (in_accept) begin
                    state_next = LOAD;
                    count_next = 4'd1;
                end
            end
            LOAD: begin
                if (in_accept) begin
                    count_next = count_reg + 4'd1;
                    if (count_reg == LAST_BEAT) state_next = START;
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                if (core_done) state_next = UNLOAD;
            end
            UNLOAD: begin
                if (out_xfer) begin
                    count_next = count_reg + 4'd1;
                    if (count_reg == LAST_BEAT) state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        in_ready_next   = (state_next == IDLE) || (state_next == LOAD);
        core_start_next = (state_next == START);
        out_valid_next  = (state_next == UNLOAD);
        out_last_next   = (state_next == UNLOAD) && (count_next == LAST_BEAT);
        done_next       = (state_reg == UNLOAD) && out_xfer && (count_reg == LAST_BEAT);
        busy_next       = (state_next != IDLE);
    end

    logic [CELL-1:0]      pt_msb;
    logic [TK_Z*CELL-1:0] tk_msb;
    logic                 unused_msb;

    skinny_cell_shifter #(.WIDTH(BLOCK_BITS), .STEP(CELL)) u_pt_shifter (
        .clock     (clock),
        .reset     (reset),
        .load      (1'b0),
        .load_data ('0),
        .shift     (in_accept),
        .shift_in  (in_pt),
        .data      (core_pt),
        .msb       (pt_msb)
    );

    skinny_cell_shifter #(.WIDTH(TK_BITS), .STEP(TK_Z*CELL)) u_tk_shifter (
        .clock     (clock),
        .reset     (reset),
        .load      (1'b0),
        .load_data ('0),
        .shift     (in_accept),
        .shift_in  (in_tk),
        .data      (core_tk),
        .msb       (tk_msb)
    );

    // Ciphertext drains MSB cell first; zeros fill in behind it.
    logic [BLOCK_BITS-1:0] ct_data;

    skinny_cell_shifter #(.WIDTH(BLOCK_BITS), .STEP(CELL)) u_ct_shifter (
        .clock     (clock),
        .reset     (reset),
        .load      (ct_capture),
        .load_data (core_ct),
        .shift     (out_xfer),
        .shift_in  ('0),
        .data      (ct_data),
        .msb       (out_ct)
    );

    assign unused_msb = ^{pt_msb, tk_msb, ct_data};

    assign in_ready   = in_ready_reg;
    assign core_start = core_start_reg;
    assign out_valid  = out_valid_reg;
    assign out_last   = out_last_reg;
    assign done       = done_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_skinny_serial_io.sv
// Bench for skinny_serial_io: a 128/384 and a 64/128 instance run in lockstep
// on a shared beat stream, each checked against a simple serial/parallel model.
module tb_skinny_serial_io;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic core_done = 1'b0;
    logic [7:0]   in_pt = '0;
    logic [23:0]  in_tk = '0;
    logic [127:0] core_ct_a = '0;
    logic [63:0]  core_ct_b = '0;

    logic         in_ready_a, core_start_a, out_valid_a, out_last_a, done_a, busy_a;
    logic [127:0] core_pt_a;
    logic [383:0] core_tk_a;
    logic [7:0]   out_ct_a;

    logic         in_ready_b, core_start_b, out_valid_b, out_last_b, done_b, busy_b;
    logic [63:0]  core_pt_b;
    logic [127:0] core_tk_b;
    logic [3:0]   out_ct_b;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    always #5 clock = ~clock;

    skinny_serial_io #(.BLOCK_BITS(128), .TK_Z(3)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_pt(in_pt), .in_tk(in_tk),
        .core_start(core_start_a), .core_pt(core_pt_a), .core_tk(core_tk_a),
        .core_done(core_done), .core_ct(core_ct_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_ct(out_ct_a),
        .out_last(out_last_a), .done(done_a), .busy(busy_a)
    );

    skinny_serial_io #(.BLOCK_BITS(64), .TK_Z(2)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_pt(in_pt[3:0]), .in_tk(in_tk[7:0]),
        .core_start(core_start_b), .core_pt(core_pt_b), .core_tk(core_tk_b),
        .core_done(core_done), .core_ct(core_ct_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_ct(out_ct_b),
        .out_last(out_last_b), .done(done_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        ncyc++;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [383:0] rand384();
        return {rand128(), rand128(), rand128()};
    endfunction

    // One reset cycle: everything must clear, then in_ready comes up.
    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; core_done = 1'b0;
        step();
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_busy_b", busy_b, 1'b0);
        chk("rst_in_ready", in_ready_a, 1'b0);
        chk("rst_core_start", core_start_a, 1'b0);
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_out_last", out_last_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_core_pt", core_pt_a, '0);
        chk("rst_core_tk", core_tk_a, '0);
        chk("rst_out_ct", out_ct_a, '0);
        chk("rst_core_pt_b", core_pt_b, '0);
        reset = 1'b1;
        step();
        chk("post_rst_in_ready_a", in_ready_a, 1'b1);
        chk("post_rst_in_ready_b", in_ready_b, 1'b1);
        chk("post_rst_busy", busy_a, 1'b0);
        $display("txn reset: total=%0d bad=%0d", total, bad);
    endtask

    // Full load/start/wait/unload transaction. abort_* = beat index at which
    // reset is pulsed instead (>=16 means run to completion).
    task automatic run_txn(input logic [127:0] pt, input logic [383:0] tk,
                           input logic [127:0] ct_a, input logic [63:0] ct_b,
                           input int vp, input int rp, input int delay,
                           input int abort_load, input int abort_unload);
        logic [63:0]  exp_pt_b;
        logic [127:0] exp_tk_b;
        int nb, k, first, guard;
        logic rdy, ov;
        nb = 0; k = 0; guard = 0; first = -1;
        exp_pt_b = '0; exp_tk_b = '0;

        while (nb < 16 && guard < 2000) begin
            if (nb == abort_load) begin
                do_reset();
                return;
            end
            rdy = in_ready_a;
            chk("ld_ready_a", rdy, 1'b1);
            chk("ld_ready_b", in_ready_b, 1'b1);
            chk("ld_start", core_start_a, 1'b0);
            in_valid  = ($urandom_range(99) < vp);
            in_pt     = 8'(pt >> (120 - 8 * nb));
            in_tk     = 24'(tk >> (360 - 24 * nb));
            core_done = ($urandom_range(3) == 0);
            core_ct_a = rand128();
            core_ct_b = 64'(rand128());
            step();
            if (in_valid && rdy) begin
                if (first < 0) first = ncyc - 1;
                exp_pt_b = (exp_pt_b << 4) | 64'(in_pt[3:0]);
                exp_tk_b = (exp_tk_b << 8) | 128'(in_tk[7:0]);
                nb++;
            end
            guard++;
        end
        chk("ld_beats", nb, 16);

        // START cycle: stray in_valid and core_done must both be ignored.
        in_valid = 1'b1; in_pt = 8'($urandom); in_tk = 24'($urandom); core_done = 1'b1;
        chk("start_a", core_start_a, 1'b1);
        chk("start_b", core_start_b, 1'b1);
        if (vp == 100) chk("start_latency", ncyc - first, 16);
        chk("start_in_ready", in_ready_a, 1'b0);
        chk("start_busy", busy_a, 1'b1);
        chk("core_pt_a", core_pt_a, pt);
        chk("core_tk_a", core_tk_a, tk);
        chk("core_pt_b", core_pt_b, exp_pt_b);
        chk("core_tk_b", core_tk_b, exp_tk_b);
        step();
        chk("wait_start_low", core_start_a, 1'b0);
        chk("wait_out_valid", out_valid_a, 1'b0);
        chk("wait_in_ready", in_ready_a, 1'b0);

        for (int i = 1; i < delay; i++) begin
            core_done = 1'b0;
            in_valid  = $urandom_range(1);
            step();
            chk("wait_idle_out", out_valid_a, 1'b0);
        end
        core_done = 1'b1; core_ct_a = ct_a; core_ct_b = ct_b; in_valid = 1'b0;
        step();
        core_done = 1'b0; core_ct_a = rand128(); core_ct_b = 64'(rand128());
        chk("ul_first_valid", out_valid_a, 1'b1);
        chk("core_pt_hold", core_pt_a, pt);

        guard = 0;
        while (k < 16 && guard < 2000) begin
            if (k == abort_unload) begin
                do_reset();
                return;
            end
            ov = out_valid_a;
            chk("ul_valid_a", ov, 1'b1);
            chk("ul_valid_b", out_valid_b, 1'b1);
            chk("ul_ct_a", out_ct_a, 8'(ct_a >> (120 - 8 * k)));
            chk("ul_ct_b", out_ct_b, 4'(ct_b >> (60 - 4 * k)));
            chk("ul_last_a", out_last_a, (k == 15));
            chk("ul_last_b", out_last_b, (k == 15));
            chk("ul_done", done_a, 1'b0);
            chk("ul_in_ready", in_ready_a, 1'b0);
            out_ready = ($urandom_range(99) < rp);
            in_valid  = $urandom_range(1);
            in_pt     = 8'($urandom);
            step();
            if (ov && out_ready) k++;
            guard++;
        end
        chk("ul_beats", k, 16);
        out_ready = 1'b0; in_valid = 1'b0;
        chk("done_a", done_a, 1'b1);
        chk("done_b", done_b, 1'b1);
        chk("end_out_valid", out_valid_a, 1'b0);
        chk("end_in_ready", in_ready_a, 1'b1);
        chk("end_busy", busy_a, 1'b0);
        chk("end_core_pt_a", core_pt_a, pt);
        chk("end_core_pt_b", core_pt_b, exp_pt_b);
        step();
        chk("done_pulse", done_a, 1'b0);
        $display("txn pt=%h ct=%h: total=%0d bad=%0d", pt, ct_a, total, bad);
    endtask

    initial begin
        do_reset();
        run_txn(128'ha3994b66ad85a3459f44e92b08f550cb,
                384'hdf889548cfc7ea52d296339301797449ab588a34a47f1ab2dfe9c8293fbea9a5ab1afac2611012cd8cef952618c3ebe8,
                128'h94ecf589e2017c601b38c6346a10dcfa, 64'h5ed7b1ae5fd3e6a4,
                100, 100, 37, 99, 99);
        run_txn(128'ha3994b66ad85a3459f44e92b08f550cb,
                384'hdf889548cfc7ea52d296339301797449ab588a34a47f1ab2dfe9c8293fbea9a5ab1afac2611012cd8cef952618c3ebe8,
                128'h94ecf589e2017c601b38c6346a10dcfa, 64'(rand128()),
                50, 50, 5, 99, 99);
        run_txn(rand128(), rand384(), rand128(), 64'(rand128()), 50, 50, 1, 99, 99);
        run_txn(rand128(), rand384(), rand128(), 64'(rand128()), 100, 100, 3, 7, 99);
        run_txn(rand128(), rand384(), rand128(), 64'(rand128()), 70, 60, 12, 99, 99);
        run_txn(rand128(), rand384(), rand128(), 64'(rand128()), 100, 100, 2, 99, 9);
        run_txn(rand128(), rand384(), rand128(), 64'(rand128()), 100, 100, 1, 99, 99);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
